fg_dac_spi_driver: RTL and testbench

- Downstream stage of function_generater: consumes its 32-bit data sample bus and drives an external 16-bit SPI DAC.
- Decimates the generator's per-clock output to a fixed DAC update rate.
- Holds one pending sample and serializes it MSB-first over a 3-wire SPI link (cs_n, sclk, mosi).
- Reports overruns when a new sample replaces an unsent one.

---
 rtl/fg_dac_spi_driver.sv | 183 ++++++++++++++++++
 tb/tb_fg_dac_spi_driver.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fg_dac_spi_driver.sv
// Decimates the function generator's sample stream and drives a 16-bit SPI DAC
// over cs_n/sclk/mosi, with a single-entry hold buffer and overrun counting.
module fg_dac_spi_driver #(
    parameter int SAMPLE_DIV    = 100,
    parameter int SCLK_DIV      = 2,
    parameter int CS_GAP        = 4,
    parameter int OFFSET_BINARY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [31:0] data_in,
    output logic        dac_cs_n,
    output logic        dac_sclk,
    output logic        dac_mosi,
    output logic        busy,
    output logic        hold_valid,
    output logic [7:0]  overrun_count
);

    localparam logic [15:0] RATE_LAST  = 16'(SAMPLE_DIV - 1);
    localparam logic [7:0]  HALF_LAST  = 8'(SCLK_DIV - 1);
    localparam logic [7:0]  GAP_LAST   = 8'(CS_GAP - 1);
    localparam logic [4:0]  FRAME_BITS = 5'd16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] rate_cnt_reg, rate_cnt_next;
    logic [15:0] hold_word_reg, hold_word_next;
    logic        hold_valid_reg, hold_valid_next;
    logic [7:0]  overrun_reg, overrun_next;
    logic [15:0] shift_reg, shift_next;
    logic [4:0]  bit_cnt_reg, bit_cnt_next;
    logic [7:0]  phase_cnt_reg, phase_cnt_next;
    logic        cs_n_reg, cs_n_next;
    logic        sclk_reg, sclk_next;
    logic        mosi_reg, mosi_next;

    logic [15:0] capture_word;
    logic        rate_tick;
    logic        consume;
    logic        unused_low_bits;

    // Only the upper half of the generator bus carries the sample value.
    assign unused_low_bits = ^data_in[15:0];

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_fmt
            if (gi == 15 && OFFSET_BINARY != 0) begin : g_flip
                assign capture_word[gi] = ~data_in[16 + gi];
            end else begin : g_pass
                assign capture_word[gi] = data_in[16 + gi];
            end
        end
    endgenerate

    assign rate_tick = enable && (rate_cnt_reg == RATE_LAST);
    assign consume   = (state_reg == IDLE) && hold_valid_reg;

    always_comb begin
        state_next      = state_reg;
        rate_cnt_next   = rate_cnt_reg;
        hold_word_next  = hold_word_reg;
        hold_valid_next = hold_valid_reg;
        overrun_next    = overrun_reg;
        shift_next      = shift_reg;
        bit_cnt_next    = bit_cnt_reg;
        phase_cnt_next  = phase_cnt_reg;
        cs_n_next       = cs_n_reg;
        sclk_next       = sclk_reg;
        mosi_next       = mosi_reg;

        if (!enable || rate_tick) begin
            rate_cnt_next = 16'd0;
        end else begin
            rate_cnt_next = rate_cnt_reg + 16'd1;
        end

        // A capture coinciding with consumption is not an overrun: the FSM
        // takes the old word this cycle while the new one lands in the buffer.
        if (rate_tick) begin
            hold_word_next  = capture_word;
            hold_valid_next = 1'b1;
            if (hold_valid_reg && !consume && overrun_reg != 8'hFF) begin
                overrun_next = overrun_reg + 8'd1;
            end
        end else if (!enable || consume) begin
            hold_valid_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                if (hold_valid_reg) begin
                    state_next     = SHIFT;
                    shift_next     = hold_word_reg;
                    mosi_next      = hold_word_reg[15];
                    cs_n_next      = 1'b0;
                    sclk_next      = 1'b0;
                    bit_cnt_next   = 5'd0;
                    phase_cnt_next = 8'd0;
                end
            end
            SHIFT: begin
                if (phase_cnt_reg == HALF_LAST) begin
                    phase_cnt_next = 8'd0;
                    if (!sclk_reg) begin
                        sclk_next    = 1'b1;
                        bit_cnt_next = bit_cnt_reg + 5'd1;
                    end else begin
                        sclk_next = 1'b0;
                        // The falling edge after the last rising edge closes the frame.
                        if (bit_cnt_reg == FRAME_BITS) begin
                            cs_n_next  = 1'b1;
                            mosi_next  = 1'b0;
                            state_next = GAP;
                        end else begin
                            shift_next = {shift_reg[14:0], 1'b0};
                            mosi_next  = shift_reg[14];
                        end
                    end
                end else begin
                    phase_cnt_next = phase_cnt_reg + 8'd1;
                end
            end
            GAP: begin
                if (phase_cnt_reg == GAP_LAST) begin
                    phase_cnt_next = 8'd0;
                    state_next     = IDLE;
                end else begin
                    phase_cnt_next = phase_cnt_reg + 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cs_n_next  = 1'b1;
                sclk_next  = 1'b0;
                mosi_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            rate_cnt_reg   <= 16'd0;
            hold_word_reg  <= 16'd0;
            hold_valid_reg <= 1'b0;
            overrun_reg    <= 8'd0;
            shift_reg      <= 16'd0;
            bit_cnt_reg    <= 5'd0;
            phase_cnt_reg  <= 8'd0;
            cs_n_reg       <= 1'b1;
            sclk_reg       <= 1'b0;
            mosi_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            rate_cnt_reg   <= rate_cnt_next;
            hold_word_reg  <= hold_word_next;
            hold_valid_reg <= hold_valid_next;
            overrun_reg    <= overrun_next;
            shift_reg      <= shift_next;
            bit_cnt_reg    <= bit_cnt_next;
            phase_cnt_reg  <= phase_cnt_next;
            cs_n_reg       <= cs_n_next;
            sclk_reg       <= sclk_next;
            mosi_reg       <= mosi_next;
        end
    end

    assign dac_cs_n      = cs_n_reg;
    assign dac_sclk      = sclk_reg;
    assign dac_mosi      = mosi_reg;
    assign busy          = (state_reg == SHIFT) || (state_reg == GAP);
    assign hold_valid    = hold_valid_reg;
    assign overrun_count = overrun_reg;

endmodule

// File: tb/tb_fg_dac_spi_driver.sv
// Bench for fg_dac_spi_driver: two instances (offset-binary slow rate, raw fast rate
// with overruns) observed by a pin-level SPI decoder and a sample-level scoreboard.
module tb_fg_dac_spi_driver;

    localparam int SD  = 2;
    localparam int GAP = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_a = 1'b0, en_b = 1'b0;
    logic [31:0] din_a = '0, din_b = '0;
    logic        cs_n_a, sclk_a, mosi_a, busy_a, hv_a;
    logic        cs_n_b, sclk_b, mosi_b, busy_b, hv_b;
    logic [7:0]  oc_a, oc_b;

    fg_dac_spi_driver #(.SAMPLE_DIV(100), .SCLK_DIV(SD), .CS_GAP(GAP), .OFFSET_BINARY(1)) u_a (
        .clk(clk), .rst(rst), .enable(en_a), .data_in(din_a),
        .dac_cs_n(cs_n_a), .dac_sclk(sclk_a), .dac_mosi(mosi_a),
        .busy(busy_a), .hold_valid(hv_a), .overrun_count(oc_a));

    fg_dac_spi_driver #(.SAMPLE_DIV(20), .SCLK_DIV(SD), .CS_GAP(GAP), .OFFSET_BINARY(0)) u_b (
        .clk(clk), .rst(rst), .enable(en_b), .data_in(din_b),
        .dac_cs_n(cs_n_b), .dac_sclk(sclk_b), .dac_mosi(mosi_b),
        .busy(busy_b), .hold_valid(hv_b), .overrun_count(oc_b));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int d, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", name, d, cyc, act, exp);
        end
    endtask

    // Scoreboard state, one slot per instance
    int          div_p[2] = '{100, 20};
    bit          ob_p[2]  = '{1'b1, 1'b0};
    int          run[2], ovr[2], rises[2], frames[2], coinc[2];
    int          start_cyc[2], rise_cyc[2], fall_cyc[2], prev_fall_cyc[2];
    bit          pending[2], had_frame[2], cs_prev[2], sclk_prev[2], mosi_prev[2];
    logic [15:0] hold_w[2], exp_w[2], shw[2], last_word[2];
    bit          en_s[2];
    logic [31:0] din_s[2];
    bit          rst_s = 1'b1;

    function automatic logic [15:0] fmt(input logic [31:0] w, input bit ob);
        return ob ? (w[31:16] ^ 16'h8000) : w[31:16];
    endfunction

    task automatic mon(input int d, input logic cs, input logic sclk, input logic mosi,
                       input logic hv, input logic bsy, input logic [7:0] oc);
        bit tick, fell, rose, exp_fall, exp_busy;
        if (rst || rst_s) begin
            run[d] = 0; ovr[d] = 0; rises[d] = 0; pending[d] = 0; had_frame[d] = 0;
            hold_w[d] = '0; shw[d] = '0;
            cs_prev[d] = 1'b1; sclk_prev[d] = 1'b0; mosi_prev[d] = 1'b0;
            return;
        end
        // A capture happens on every DIV-th consecutive enabled clock.
        tick = en_s[d] && (((run[d] + 1) % div_p[d]) == 0);
        run[d] = en_s[d] ? run[d] + 1 : 0;
        fell = cs_prev[d] && !cs;
        rose = !cs_prev[d] && cs;
        exp_fall = pending[d] && cs_prev[d] && (!had_frame[d] || (cyc - rise_cyc[d]) >= GAP + 1);
        chk("cs_fall", d, fell, exp_fall);
        if (fell) begin
            exp_w[d] = hold_w[d];
            rises[d] = 0;
            shw[d] = '0;
            start_cyc[d] = cyc;
            prev_fall_cyc[d] = fall_cyc[d];
            fall_cyc[d] = cyc;
        end
        if (tick) begin
            if (pending[d] && !fell && ovr[d] < 255) ovr[d]++;
            if (pending[d] && fell) coinc[d]++;
            hold_w[d] = fmt(din_s[d], ob_p[d]);
        end
        pending[d] = en_s[d] ? (tick || (pending[d] && !fell)) : 1'b0;
        chk("hold_valid", d, hv, pending[d]);
        chk("overrun", d, oc, ovr[d]);
        if (!cs && sclk && !sclk_prev[d]) begin
            rises[d]++;
            shw[d] = {shw[d][14:0], mosi};
            chk("mosi_stable_at_rise", d, mosi, mosi_prev[d]);
        end
        if (rose) begin
            chk("edges", d, rises[d], 16);
            chk("word", d, shw[d], exp_w[d]);
            chk("frame_len", d, cyc - start_cyc[d], 32 * SD);
            last_word[d] = shw[d];
            frames[d]++;
            had_frame[d] = 1'b1;
            rise_cyc[d] = cyc;
        end
        if (cs) begin
            chk("sclk_idle", d, sclk, 0);
            chk("mosi_idle", d, mosi, 0);
        end
        exp_busy = !cs || (had_frame[d] && (cyc - rise_cyc[d]) < GAP);
        chk("busy", d, bsy, exp_busy);
        cs_prev[d] = cs; sclk_prev[d] = sclk; mosi_prev[d] = mosi;
    endtask

    always @(negedge clk) begin
        mon(0, cs_n_a, sclk_a, mosi_a, hv_a, busy_a, oc_a);
        mon(1, cs_n_b, sclk_b, mosi_b, hv_b, busy_b, oc_b);
        rst_s = rst;
        en_s[0] = en_a; en_s[1] = en_b;
        din_s[0] = din_a; din_s[1] = din_b;
    end

    task automatic wait_bit(input int n, input string nm);
        int k;
        for (k = 0; k < 400; k++) begin
            @(posedge clk); #2;
            if (!cs_n_a && rises[0] == n) break;
        end
        chk(nm, 0, (k < 400), 1);
    endtask

    typedef struct {
        logic [31:0] din;
        logic [15:0] exp_ob;
        logic [15:0] exp_raw;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int f0, f1, e_cyc, k;
        vecs[0] = '{32'h7FFF_0000, 16'hFFFF, 16'h7FFF};
        vecs[1] = '{32'h8000_1234, 16'h0000, 16'h8000};
        vecs[2] = '{32'h0000_ABCD, 16'h8000, 16'h0000};
        vecs[3] = '{32'hC3A5_0000, 16'h43A5, 16'hC3A5};
        vecs[4] = '{32'h5A5A_FFFF, 16'hDA5A, 16'h5A5A};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs_n", 0, cs_n_a, 1);
        chk("rst_sclk", 0, sclk_a, 0);
        chk("rst_mosi", 0, mosi_a, 0);
        chk("rst_busy", 0, busy_a, 0);
        chk("rst_hold_valid", 0, hv_a, 0);
        chk("rst_overrun", 0, oc_a, 0);
        #1 rst = 1'b0;

        // Reset in the middle of a frame aborts it at once
        @(posedge clk); #1;
        din_a = 32'h7FFF_0000; din_b = 32'hC3A5_0000;
        en_a = 1'b1; en_b = 1'b1;
        wait_bit(7, "wait_bit7");
        rst = 1'b1;
        #1;
        chk("midrst_cs_n", 0, cs_n_a, 1);
        chk("midrst_sclk", 0, sclk_a, 0);
        chk("midrst_mosi", 0, mosi_a, 0);
        chk("midrst_hold_valid", 0, hv_a, 0);
        chk("midrst_overrun", 1, oc_b, 0);
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b0;

        // Table of formats
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            din_a = vecs[i].din; din_b = vecs[i].din;
            f0 = frames[0]; f1 = frames[1];
            for (k = 0; k < 600; k++) begin
                @(posedge clk); #2;
                if (frames[0] >= f0 + 3 && frames[1] >= f1 + 3) break;
            end
            chk("vec_timeout", 0, (k < 600), 1);
            chk("vec_word_ob", 0, last_word[0], vecs[i].exp_ob);
            chk("vec_word_raw", 1, last_word[1], vecs[i].exp_raw);
        end

        // Random samples against the scoreboard
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            din_a = $urandom; din_b = $urandom;
        end
        #1;
        chk("rate_spacing", 0, fall_cyc[0] - prev_fall_cyc[0], 100);
        chk("no_overrun_slow", 0, oc_a, 0);

        // Enable dropped during bit 3: frame completes, then silence
        wait_bit(3, "wait_bit3");
        en_a = 1'b0;
        f0 = frames[0];
        repeat (80) @(posedge clk);
        #2;
        chk("drop_frame_done", 0, frames[0], f0 + 1);
        chk("drop_hold_valid", 0, hv_a, 0);
        repeat (200) @(posedge clk);
        #2;
        chk("drop_silent", 0, frames[0], f0 + 1);
        @(posedge clk); #1;
        en_a = 1'b1;
        e_cyc = cyc;
        for (k = 0; k < 300; k++) begin
            @(posedge clk); #2;
            if (fall_cyc[0] > e_cyc) break;
        end
        chk("reenable_latency", 0, fall_cyc[0] - e_cyc, 101);

        // Fast instance saturates its overrun counter
        for (k = 0; k < 10000; k++) begin
            @(posedge clk); #2;
            din_b = $urandom;
            if (oc_b == 8'hFF) break;
        end
        chk("overrun_saturated", 1, oc_b, 255);
        repeat (100) @(posedge clk);
        #2;
        chk("overrun_held", 1, oc_b, 255);
        chk("coincidence_seen", 1, (coinc[1] > 0), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog dut0 cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
